// File: rtl/usb_bus_model_if.sv
// Line-side bundle of the USB bus model: per-port drive inputs, pull-up
// selects and status clear in, resolved line and bus status out.
interface usb_bus_model_if #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1,
    parameter int CNT_W     = 16
);
    logic [2*NUM_PORTS-1:0] portDataIn;
    logic [NUM_PORTS-1:0]   portOE;
    logic                   dPlusPullup;
    logic                   dMinusPullup;
    logic                   clearStatus;
    logic [1:0]             busDataOut;
    logic [1:0]             lineState;
    logic                   busDriven;
    logic [IDX_W-1:0]       driverIdx;
    logic                   contention;
    logic [CNT_W-1:0]       contentionCount;
    logic                   busResetDet;
    logic                   busIdle;

    modport master (
        output portDataIn, portOE, dPlusPullup, dMinusPullup, clearStatus,
        input  busDataOut, lineState, busDriven, driverIdx, contention,
               contentionCount, busResetDet, busIdle
    );

    modport slave (
        input  portDataIn, portOE, dPlusPullup, dMinusPullup, clearStatus,
        output busDataOut, lineState, busDriven, driverIdx, contention,
               contentionCount, busResetDet, busIdle
    );
endinterface

// File: rtl/usb_bus_model.sv
// Clocked USB D+/D- line resolver for NUM_PORTS drivers: line-state decode,
// bus reset / idle detection and sticky contention statistics.
module usb_bus_model #(
    parameter int NUM_PORTS   = 2,
    parameter int IDX_W       = 1,
    parameter int RESET_TICKS = 48,
    parameter int IDLE_TICKS  = 8,
    parameter int CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    usb_bus_model_if.slave bus
);
    localparam int SE_W = $clog2(RESET_TICKS + 1);
    localparam int ID_W = $clog2(IDLE_TICKS + 1);

    logic [NUM_PORTS-1:0] w_oeM1;
    logic                 w_anyOE;
    logic                 w_multiOE;
    logic                 w_oneOE;
    logic [IDX_W-1:0]     w_idx;
    logic [1:0]           w_drv;
    logic [1:0]           w_line;
    logic [1:0]           w_j;
    logic [1:0]           w_ls;
    logic                 w_pullChg;

    logic [1:0]       r_busData;
    logic [1:0]       r_ls;
    logic             r_driven;
    logic [IDX_W-1:0] r_idx;
    logic             r_cont;
    logic [CNT_W-1:0] r_cnt;
    logic [SE_W-1:0]  r_seCnt;
    logic [ID_W-1:0]  r_idleCnt;
    logic [1:0]       r_pu;
    logic             r_puVld;

    always_comb begin
        w_oeM1    = bus.portOE - NUM_PORTS'(1);
        w_anyOE   = |bus.portOE;
        // Clearing the lowest set bit leaves something only if >= 2 OEs are set.
        w_multiOE = |(bus.portOE & w_oeM1);
        w_oneOE   = w_anyOE && !w_multiOE;

        w_idx = '0;
        w_drv = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.portOE[i]) begin
                w_idx = IDX_W'(i);
                w_drv = bus.portDataIn[2*i +: 2];
            end
        end

        w_j = bus.dPlusPullup ? 2'b10 : 2'b01;

        if (w_multiOE)
            w_line = 2'bxx;
        else if (w_anyOE)
            w_line = w_drv;
        else
            w_line = {bus.dPlusPullup, bus.dMinusPullup};

        if (w_multiOE)
            w_ls = 2'd3;
        else if (w_line == 2'b00)
            w_ls = 2'd0;
        else if (w_line == 2'b11)
            w_ls = 2'd3;
        else if (w_line == w_j)
            w_ls = 2'd1;
        else
            w_ls = 2'd2;

        // A pull-up swap redefines J, so an idle run must start over.
        w_pullChg = r_puVld && ({bus.dPlusPullup, bus.dMinusPullup} != r_pu);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busData <= '0;
            r_ls      <= '0;
            r_driven  <= 1'b0;
            r_idx     <= '0;
            r_cont    <= 1'b0;
            r_cnt     <= '0;
            r_seCnt   <= '0;
            r_idleCnt <= '0;
            r_pu      <= '0;
            r_puVld   <= 1'b0;
        end else begin
            r_busData <= w_line;
            r_ls      <= w_ls;
            r_driven  <= w_oneOE;
            if (w_oneOE)
                r_idx <= w_idx;

            if (w_multiOE) begin
                r_cont <= 1'b1;
                if (bus.clearStatus)
                    r_cnt <= CNT_W'(1);
                else if (!(&r_cnt))
                    r_cnt <= r_cnt + CNT_W'(1);
            end else if (bus.clearStatus) begin
                r_cont <= 1'b0;
                r_cnt  <= '0;
            end

            if (!w_multiOE && w_line == 2'b00) begin
                if (r_seCnt != SE_W'(RESET_TICKS))
                    r_seCnt <= r_seCnt + SE_W'(1);
            end else begin
                r_seCnt <= '0;
            end

            if (!w_anyOE && w_line == w_j && !w_pullChg) begin
                if (r_idleCnt != ID_W'(IDLE_TICKS))
                    r_idleCnt <= r_idleCnt + ID_W'(1);
            end else begin
                r_idleCnt <= '0;
            end

            r_pu    <= {bus.dPlusPullup, bus.dMinusPullup};
            r_puVld <= 1'b1;
        end
    end

    assign bus.busDataOut      = r_busData;
    assign bus.lineState       = r_ls;
    assign bus.busDriven       = r_driven;
    assign bus.driverIdx       = r_idx;
    assign bus.contention      = r_cont;
    assign bus.contentionCount = r_cnt;
    assign bus.busResetDet     = (r_seCnt == SE_W'(RESET_TICKS));
    assign bus.busIdle         = (r_idleCnt == ID_W'(IDLE_TICKS));
endmodule

// File: tb/tb_usb_bus_model.sv
// Bench for usb_bus_model: directed scenarios plus randomized held-input runs
// checked against a per-edge reference model of the line rules.
module tb_usb_bus_model;
    localparam int NP   = 3;
    localparam int IW   = 2;
    localparam int RT   = 48;
    localparam int IT   = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    usb_bus_model_if #(.NUM_PORTS(NP), .IDX_W(IW), .CNT_W(CW)) ifc ();

    usb_bus_model #(
        .NUM_PORTS(NP), .IDX_W(IW), .RESET_TICKS(RT), .IDLE_TICKS(IT), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per rising edge.
    logic [1:0] m_data;
    int         m_ls, m_idx, m_cnt, m_se, m_idle;
    bit         m_driven, m_cont, m_x, m_puvld;
    logic [1:0] m_pu;

    task automatic model_edge();
        int         n, idx;
        logic [1:0] ln, j, pu;
        logic [2*NP-1:0] pd;
        pd = ifc.portDataIn;
        pu = {ifc.dPlusPullup, ifc.dMinusPullup};
        if (!rst) begin
            m_data = 2'b00; m_ls = 0; m_driven = 0; m_idx = 0; m_cont = 0;
            m_cnt = 0; m_se = 0; m_idle = 0; m_x = 0; m_puvld = 0; m_pu = 2'b00;
            return;
        end
        n   = $countones(ifc.portOE);
        idx = 0;
        j   = ifc.dPlusPullup ? 2'b10 : 2'b01;
        for (int i = 0; i < NP; i++) if (ifc.portOE[i]) idx = i;
        if (n == 0)      ln = pu;
        else if (n == 1) ln = pd[2*idx +: 2];
        else             ln = 2'b11;
        m_x      = (n >= 2);
        m_data   = ln;
        m_driven = (n == 1);
        if (n == 1) m_idx = idx;
        if (n >= 2 || ln == 2'b11) m_ls = 3;
        else if (ln == 2'b00)      m_ls = 0;
        else if (ln == j)          m_ls = 1;
        else                       m_ls = 2;
        if (n >= 2) begin
            m_cont = 1;
            m_cnt  = ifc.clearStatus ? 1 : ((m_cnt == MAXC) ? MAXC : m_cnt + 1);
        end else if (ifc.clearStatus) begin
            m_cont = 0;
            m_cnt  = 0;
        end
        m_se   = (n <= 1 && ln == 2'b00) ? ((m_se < RT) ? m_se + 1 : RT) : 0;
        m_idle = (n == 0 && ln == j && (!m_puvld || pu == m_pu))
                 ? ((m_idle < IT) ? m_idle + 1 : IT) : 0;
        m_pu    = pu;
        m_puvld = 1;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] oe, input logic [2*NP-1:0] d,
                         input logic dp, input logic dm, input logic clr);
        ifc.portOE       = oe;
        ifc.portDataIn   = d;
        ifc.dPlusPullup  = dp;
        ifc.dMinusPullup = dm;
        ifc.clearStatus  = clr;
    endtask

    task automatic test_reset();
        rst = 0;
        drive(3'b011, 6'b111111, 1'b1, 1'b1, 1'b0);
        cyc(); cyc();
        n_tests += 9;
        if (ifc.busDataOut !== 2'b00) begin n_fail++; $display("FAIL rst_data got=%b exp=00", ifc.busDataOut); end
        if (ifc.lineState !== 2'd0) begin n_fail++; $display("FAIL rst_ls got=%0d exp=0", ifc.lineState); end
        if (ifc.busDriven !== 1'b0) begin n_fail++; $display("FAIL rst_driven got=%b exp=0", ifc.busDriven); end
        if (ifc.driverIdx !== '0) begin n_fail++; $display("FAIL rst_idx got=%0d exp=0", ifc.driverIdx); end
        if (ifc.contention !== 1'b0) begin n_fail++; $display("FAIL rst_cont got=%b exp=0", ifc.contention); end
        if (ifc.contentionCount !== '0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", ifc.contentionCount); end
        if (ifc.busResetDet !== 1'b0) begin n_fail++; $display("FAIL rst_resetdet got=%b exp=0", ifc.busResetDet); end
        if (ifc.busIdle !== 1'b0) begin n_fail++; $display("FAIL rst_idle got=%b exp=0", ifc.busIdle); end
        if (dut.r_seCnt !== '0) begin n_fail++; $display("FAIL rst_secnt got=%0d exp=0", dut.r_seCnt); end
        rst = 1;
    endtask

    task automatic test_single_driver();
        drive(3'b010, 6'b00_10_00, 1'b1, 1'b0, 1'b0);
        cyc();
        n_tests += 5;
        if (ifc.busDataOut !== 2'b10) begin n_fail++; $display("FAIL single_data got=%b exp=10", ifc.busDataOut); end
        if (ifc.lineState !== 2'd1) begin n_fail++; $display("FAIL single_ls got=%0d exp=1", ifc.lineState); end
        if (ifc.busDriven !== 1'b1) begin n_fail++; $display("FAIL single_driven got=%b exp=1", ifc.busDriven); end
        if (ifc.driverIdx !== 2'd1) begin n_fail++; $display("FAIL single_idx got=%0d exp=1", ifc.driverIdx); end
        if (ifc.contention !== 1'b0) begin n_fail++; $display("FAIL single_cont got=%b exp=0", ifc.contention); end
    endtask

    task automatic test_idle();
        drive(3'b000, 6'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= IT + 2; k++) begin
            cyc();
            n_tests++;
            if (ifc.busIdle !== (k >= IT)) begin
                n_fail++; $display("FAIL idle_rise k=%0d got=%b exp=%b", k, ifc.busIdle, k >= IT);
            end
        end
        drive(3'b001, 6'b00_00_01, 1'b1, 1'b0, 1'b0);
        cyc();
        n_tests += 2;
        if (ifc.busIdle !== 1'b0) begin n_fail++; $display("FAIL idle_fall got=%b exp=0", ifc.busIdle); end
        if (ifc.lineState !== 2'd2) begin n_fail++; $display("FAIL idle_k_ls got=%0d exp=2", ifc.lineState); end
    endtask

    task automatic test_pullup_swap();
        drive(3'b000, 6'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc();
        drive(3'b000, 6'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < IT; k++) cyc();
        n_tests += 2;
        if (ifc.busIdle !== 1'b0) begin n_fail++; $display("FAIL swap_requal got=%b exp=0", ifc.busIdle); end
        if (ifc.lineState !== 2'd1) begin n_fail++; $display("FAIL swap_ls got=%0d exp=1", ifc.lineState); end
        cyc();
        n_tests++;
        if (ifc.busIdle !== 1'b1) begin n_fail++; $display("FAIL swap_idle got=%b exp=1", ifc.busIdle); end
    endtask

    task automatic test_bus_reset();
        drive(3'b001, 6'b00_00_00, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= RT; k++) begin
            cyc();
            if (k >= RT - 1) begin
                n_tests++;
                if (ifc.busResetDet !== (k == RT)) begin
                    n_fail++; $display("FAIL busreset_rise k=%0d got=%b exp=%b", k, ifc.busResetDet, k == RT);
                end
            end
        end
        drive(3'b001, 6'b00_00_10, 1'b1, 1'b0, 1'b0);
        cyc();
        n_tests += 2;
        if (ifc.busResetDet !== 1'b0) begin n_fail++; $display("FAIL busreset_fall got=%b exp=0", ifc.busResetDet); end
        if (dut.r_seCnt !== '0) begin n_fail++; $display("FAIL busreset_secnt got=%0d exp=0", dut.r_seCnt); end
    endtask

    task automatic test_contention();
        drive(3'b100, 6'b10_00_00, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(3'b011, 6'b00_01_10, 1'b1, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        n_tests += 4;
        if (ifc.lineState !== 2'd3) begin n_fail++; $display("FAIL cont_ls got=%0d exp=3", ifc.lineState); end
        if (ifc.contention !== 1'b1) begin n_fail++; $display("FAIL cont_flag got=%b exp=1", ifc.contention); end
        if (ifc.contentionCount !== 4'd3) begin n_fail++; $display("FAIL cont_cnt got=%0d exp=3", ifc.contentionCount); end
        if (ifc.driverIdx !== 2'd2) begin n_fail++; $display("FAIL cont_idx got=%0d exp=2", ifc.driverIdx); end
        drive(3'b000, 6'b0, 1'b1, 1'b0, 1'b1);
        cyc();
        n_tests += 2;
        if (ifc.contention !== 1'b0) begin n_fail++; $display("FAIL clr_flag got=%b exp=0", ifc.contention); end
        if (ifc.contentionCount !== 4'd0) begin n_fail++; $display("FAIL clr_cnt got=%0d exp=0", ifc.contentionCount); end
    endtask

    task automatic test_clear_overlap();
        drive(3'b110, 6'b0, 1'b1, 1'b0, 1'b0);
        cyc(); cyc();
        drive(3'b110, 6'b0, 1'b1, 1'b0, 1'b1);
        cyc();
        n_tests += 2;
        if (ifc.contention !== 1'b1) begin n_fail++; $display("FAIL ovl_flag got=%b exp=1", ifc.contention); end
        if (ifc.contentionCount !== 4'd1) begin n_fail++; $display("FAIL ovl_cnt got=%0d exp=1", ifc.contentionCount); end
        drive(3'b111, 6'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= MAXC + 2; k++) begin
            cyc();
            if (k >= MAXC - 1) begin
                n_tests++;
                if (ifc.contentionCount !== CW'((k < MAXC) ? k : MAXC)) begin
                    n_fail++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, ifc.contentionCount, (k < MAXC) ? k : MAXC);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(3'b011, 6'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(3'b001, 6'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cyc();
        rst = 0;
        cyc();
        n_tests += 5;
        if (ifc.contention !== 1'b0) begin n_fail++; $display("FAIL mid_cont got=%b exp=0", ifc.contention); end
        if (ifc.contentionCount !== '0) begin n_fail++; $display("FAIL mid_cnt got=%0d exp=0", ifc.contentionCount); end
        if (ifc.busDriven !== 1'b0) begin n_fail++; $display("FAIL mid_driven got=%b exp=0", ifc.busDriven); end
        if (ifc.lineState !== 2'd0) begin n_fail++; $display("FAIL mid_ls got=%0d exp=0", ifc.lineState); end
        if (dut.r_seCnt !== '0) begin n_fail++; $display("FAIL mid_secnt got=%0d exp=0", dut.r_seCnt); end
        rst = 1;
        for (int k = 1; k <= RT; k++) begin
            cyc();
            if (k >= RT - 1) begin
                n_tests++;
                if (ifc.busResetDet !== (k == RT)) begin
                    n_fail++; $display("FAIL mid_requal k=%0d got=%b exp=%b", k, ifc.busResetDet, k == RT);
                end
            end
        end
    endtask

    task automatic test_both_pullups();
        drive(3'b000, 6'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < IT + 2; k++) cyc();
        n_tests += 4;
        if (ifc.busDataOut !== 2'b11) begin n_fail++; $display("FAIL se1_data got=%b exp=11", ifc.busDataOut); end
        if (ifc.lineState !== 2'd3) begin n_fail++; $display("FAIL se1_ls got=%0d exp=3", ifc.lineState); end
        if (ifc.busIdle !== 1'b0) begin n_fail++; $display("FAIL se1_idle got=%b exp=0", ifc.busIdle); end
        if (ifc.busResetDet !== 1'b0) begin n_fail++; $display("FAIL se1_resetdet got=%b exp=0", ifc.busResetDet); end
    endtask

    task automatic test_random();
        int hold, sel;
        logic [NP-1:0] oe;
        for (int c = 0; c < 600; ) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      oe = '0;
            else if (sel < 8) oe = NP'(1) << $urandom_range(0, NP - 1);
            else              oe = NP'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            drive(oe, (2*NP)'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++, c++) begin
                cyc();
                n_tests += 8;
                if (!m_x && ifc.busDataOut !== m_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%b exp=%b", c, ifc.busDataOut, m_data); end
                if (ifc.lineState !== 2'(m_ls)) begin n_fail++; $display("FAIL rnd_ls c=%0d got=%0d exp=%0d", c, ifc.lineState, m_ls); end
                if (ifc.busDriven !== m_driven) begin n_fail++; $display("FAIL rnd_driven c=%0d got=%b exp=%b", c, ifc.busDriven, m_driven); end
                if (ifc.driverIdx !== IW'(m_idx)) begin n_fail++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, ifc.driverIdx, m_idx); end
                if (ifc.contention !== m_cont) begin n_fail++; $display("FAIL rnd_cont c=%0d got=%b exp=%b", c, ifc.contention, m_cont); end
                if (ifc.contentionCount !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, ifc.contentionCount, m_cnt); end
                if (ifc.busResetDet !== (m_se == RT)) begin n_fail++; $display("FAIL rnd_resetdet c=%0d got=%b exp=%b", c, ifc.busResetDet, m_se == RT); end
                if (ifc.busIdle !== (m_idle == IT)) begin n_fail++; $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, ifc.busIdle, m_idle == IT); end
            end
        end
        rst = 1;
    endtask

    initial begin
        drive('0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_single_driver();
        test_idle();
        test_pullup_swap();
        test_bus_reset();
        test_contention();
        test_clear_overlap();
        test_reset_mid();
        test_both_pullups();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_bus_model.md
# usb_bus_model

Clocked, parametrised USB bus line model for the test bench. Resolves the D+/D- line from NUM_PORTS driver ports plus the D+/D- pull-up selects and returns the resolved line to every port. Classifies the line state and detects bus reset (long SE0) and bus idle (long undriven J). Records driver contention with a sticky flag, a saturating counter and the last single-driver index. It replaces the two-port combinational connector between host and slave line interfaces.

## Interface
Parameters:
- NUM_PORTS, 2, number of line driver ports (>= 2)
- IDX_W, 1, width of driverIdx; 2**IDX_W >= NUM_PORTS
- RESET_TICKS, 48, consecutive SE0 cycles that constitute a bus reset (>= 2)
- IDLE_TICKS, 8, consecutive undriven-J cycles that constitute bus idle (>= 2)
- CNT_W, 16, contention counter width

Ports:
- clk  input  1  bench clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- portDataIn  input  2*NUM_PORTS  per-port {VP,VM}; port i at [2i+1:2i]
- portOE  input  NUM_PORTS  per-port output enable, bit i = port i
- dPlusPullup  input  1  1 = D+ pulled up (full speed), 0 = pulled down
- dMinusPullup  input  1  1 = D- pulled up (low speed), 0 = pulled down
- clearStatus  input  1  clears contention flag and counter
- busDataOut  output  2  registered resolved line {VP,VM}, fanned to all ports
- lineState  output  2  registered: 0 SE0, 1 J, 2 K, 3 SE1/invalid
- busDriven  output  1  registered: exactly one port drove the line
- driverIdx  output  IDX_W  index of the last single driver
- contention  output  1  sticky: two or more OEs seen
- contentionCount  output  CNT_W  saturating count of contention cycles
- busResetDet  output  1  SE0 held RESET_TICKS cycles
- busIdle  output  1  undriven J held IDLE_TICKS cycles

## Operation
- Resolution (combinational next value, nOE = popcount(portOE)):
  - nOE == 0: VP = dPlusPullup, VM = dMinusPullup.
  - nOE == 1: {VP,VM} = portDataIn of the enabled port; driverIdx <= that index.
  - nOE >= 2: busDataOut <= 2'bxx; lineState <= 3; contention <= 1; contentionCount increments, saturating at all-ones.
- J definition: dPlusPullup = 1 gives J = {1,0}, K = {0,1}. dPlusPullup = 0 gives J = {0,1}, K = {1,0}.
- Line codes: {0,0} is SE0 and {1,1} is SE1, code 3.
- Reset counter seCnt:
  - Increments, saturating at RESET_TICKS, on every cycle the next line is SE0 and nOE <= 1.
  - Clears to 0 otherwise, including on contention.
  - busResetDet = (seCnt == RESET_TICKS).
- Idle counter idleCnt:
  - Increments, saturating at IDLE_TICKS, when nOE == 0 and the next line is J.
  - Clears to 0 otherwise.
  - busIdle = (idleCnt == IDLE_TICKS).
  - A change of either pull-up redefines J, so idle re-qualifies from 0.
- clearStatus: clears contention and contentionCount. If contention occurs in the same cycle, contention stays 1 and contentionCount becomes 1.
- driverIdx holds its value while nOE is 0 or >= 2.

## Timing
- Every output is registered. Any input change shows on busDataOut, lineState, busDriven and driverIdx one clk edge later.
- seCnt and idleCnt update on the same edge as busDataOut.
  - busResetDet rises on the edge where the RESET_TICKS-th consecutive SE0 appears on busDataOut.
  - It falls on the first edge where busDataOut is not SE0.
  - busIdle rises and falls the same way against IDLE_TICKS.
- Reset (rst = 0 at a rising edge) clears everything, regardless of other inputs:
  - busDataOut 2'b00, lineState 0, busDriven 0, driverIdx 0.
  - contention 0, contentionCount 0, busResetDet 0, busIdle 0, seCnt 0, idleCnt 0.
- Reset mid-SE0 or mid-idle restarts qualification: counters start at 0 on the first edge after rst returns to 1.
- Both pull-ups set with no driver gives {1,1}, lineState 3, and neither detector advances.

## Test plan
- Port 1 enabled driving {1,0}, pull-ups 1/0: next edge busDataOut = 2'b10, lineState = 1, busDriven = 1, driverIdx = 1, contention = 0.
- No OE, dPlusPullup = 1, for IDLE_TICKS = 8 cycles: busIdle rises on the 8th edge. Enabling port 0 with K drops busIdle on the next edge.
- Port 0 drives SE0 for 48 cycles with RESET_TICKS = 48: busResetDet rises on the 48th edge. Port 0 then drives J for 1 cycle: busResetDet falls and seCnt = 0.
- Ports 0 and 1 both enabled for 3 cycles: busDataOut = xx, lineState = 3, contention = 1, contentionCount = 3, driverIdx unchanged. Asserting clearStatus with no overlap gives 0/0.
- clearStatus together with a contention cycle: contention = 1, contentionCount = 1. Forcing contentionCount to all-ones and adding one more contention cycle: the count holds at all-ones.
- Assert rst = 0 after 20 SE0 cycles with contention set: all outputs go to reset values on that edge. busResetDet then needs a further 48 SE0 cycles.
